// File: rtl/sig_capture_writer.sv
// sig_capture_writer: decimates the ECG/EMG sample stream into one frame-gated record per channel in signal RAM.
// Define SIG_CAPTURE_TRIGGER_EN to start capture on a rising ECG crossing of TRIG_LEVEL instead of immediately.
module sig_capture_writer #(
   parameter logic [11:0] ECG_BASE   = 12'h801,
   parameter logic [11:0] EMG_BASE   = 12'hC7F,
   parameter int          DEPTH      = 640,
   parameter int          DECIM      = 4
`ifdef SIG_CAPTURE_TRIGGER_EN
   ,
   parameter logic [11:0] TRIG_LEVEL = 12'd2048
`endif
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   input  logic        in_chan_i,
   input  logic [11:0] in_data_i,
   output logic        in_ready_o,
   input  logic        frame_end_i,
   output logic        mem_we_o,
   output logic [11:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        busy_o,
   output logic        capture_done_o
);
   localparam int IW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [1:0][3:0]        dec_q, dec_d;
   logic [1:0][IW-1:0]     idx_q, idx_d;
   logic                   we_q, we_d;
   logic [11:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   fin_q, fin_d;
   logic                   done_q;
   logic                   ready_q;
   logic                   keep;
`ifdef SIG_CAPTURE_TRIGGER_EN
   logic [11:0]            prev_q, prev_d;
`endif

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fin_d   = 1'b0;
      keep    = 1'b0;
`ifdef SIG_CAPTURE_TRIGGER_EN
      prev_d  = prev_q;
`endif
      case (state_q)
         IDLE: if (frame_end_i) state_d = ARM;
         ARM: begin
`ifdef SIG_CAPTURE_TRIGGER_EN
            if (in_valid_i && !in_chan_i) begin
               prev_d = in_data_i;
               if (prev_q < TRIG_LEVEL && in_data_i >= TRIG_LEVEL) begin
                  keep     = 1'b1;
                  state_d  = CAPTURE;
                  dec_d[0] = (DECIM == 1) ? 4'd0 : 4'd1;
               end
            end
`else
            state_d = CAPTURE;
`endif
         end
         CAPTURE: if (in_valid_i) begin
            dec_d[in_chan_i] = (dec_q[in_chan_i] == 4'(DECIM - 1)) ? 4'd0 : dec_q[in_chan_i] + 4'd1;
            keep = (dec_q[in_chan_i] == 4'd0) && (idx_q[in_chan_i] != IW'(DEPTH));
         end
         // frame_end during the final write cycle must not re-arm before the record is seen
         HOLD: if (frame_end_i && !fin_q) state_d = ARM;
      endcase
      if (keep) begin
         we_d             = 1'b1;
         addr_d           = (in_chan_i ? EMG_BASE : ECG_BASE) + 12'(idx_q[in_chan_i]);
         wdata_d          = {20'b0, in_data_i};
         idx_d[in_chan_i] = idx_q[in_chan_i] + IW'(1);
      end
      if (keep && state_q == CAPTURE && idx_d[0] == IW'(DEPTH) && idx_d[1] == IW'(DEPTH)) begin
         state_d = HOLD;
         fin_d   = 1'b1;
      end
      if (state_d == ARM && state_q != ARM) begin
         dec_d  = '0;
         idx_d  = '0;
`ifdef SIG_CAPTURE_TRIGGER_EN
         prev_d = '0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         dec_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         fin_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
`ifdef SIG_CAPTURE_TRIGGER_EN
         prev_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fin_q   <= fin_d;
         done_q  <= fin_q;
         ready_q <= 1'b1;
`ifdef SIG_CAPTURE_TRIGGER_EN
         prev_q  <= prev_d;
`endif
      end
   end

   assign in_ready_o     = ready_q;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign busy_o         = (state_q == ARM) || (state_q == CAPTURE);
   assign capture_done_o = done_q;
endmodule

// File: tb/tb_sig_capture_writer.sv
// tb_sig_capture_writer: directed vectors plus multi-cycle sequences for sig_capture_writer (DECIM=1 and DECIM=4 instances).
module tb_sig_capture_writer;
   logic        clk = 1'b0, rst_n = 1'b0, fe = 1'b0, v = 1'b0, ch = 1'b0;
   logic [11:0] d = '0;
   logic        rdy1, we1, busy1, done1, rdy4, we4, busy4, done4;
   logic [11:0] addr1, addr4;
   logic [31:0] wdata1, wdata4;
   int          n_chk = 0, n_fail = 0, done1_cnt = 0, done4_cnt = 0;

   always #5 clk = ~clk;

   sig_capture_writer #(.DECIM(1)) u_d1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v), .in_chan_i(ch), .in_data_i(d),
      .in_ready_o(rdy1), .frame_end_i(fe), .mem_we_o(we1), .mem_addr_o(addr1),
      .mem_wdata_o(wdata1), .busy_o(busy1), .capture_done_o(done1));

   sig_capture_writer u_d4 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v), .in_chan_i(ch), .in_data_i(d),
      .in_ready_o(rdy4), .frame_end_i(fe), .mem_we_o(we4), .mem_addr_o(addr4),
      .mem_wdata_o(wdata4), .busy_o(busy4), .capture_done_o(done4));

   always @(negedge clk) begin
      if (done1) done1_cnt++;
      if (done4) done4_cnt++;
   end

   typedef struct packed {
      logic        fe, v, ch;
      logic [11:0] d;
      logic        we;
      logic [11:0] addr, data;
      logic        busy, done;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic f, input logic vv, input logic c, input logic [11:0] dd);
      fe = f; v = vv; ch = c; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      fe = 1'b0; v = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [44:0] wr(input logic c, input int idx, input logic [11:0] dat);
      return {1'b1, (c ? 12'hC7F : 12'h801) + 12'(idx), 20'b0, dat};
   endfunction

   initial begin
      vec_t tbl[8];
      int   s, nw;
      logic [11:0] last_a;
      #2;
      chk("rst_we", we1, 0); chk("rst_addr", addr1, 0); chk("rst_wdata", wdata1, 0);
      chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_ready", rdy1, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rst", {rdy1, rdy4}, 2'b11);
`ifdef SIG_CAPTURE_TRIGGER_EN
      cyc(1, 0, 0, 0);           chk("trg_arm_busy", busy1, 1);
      cyc(0, 1, 1, 12'hFFF);     chk("trg_emg_drop", we1, 0);
      cyc(0, 1, 0, 12'd1000);    chk("trg_1000", we1, 0);
      cyc(0, 1, 0, 12'd2047);    chk("trg_2047", we1, 0);
      chk("trg_still_arm", busy1, 1);
      cyc(0, 1, 0, 12'd2048);    chk("trg_first_wr", {we1, addr1, wdata1}, wr(0, 0, 12'h800));
      cyc(0, 1, 0, 12'd5);       chk("trg_second_wr", {we1, addr1, wdata1}, wr(0, 1, 12'd5));
      cyc(0, 0, 0, 0);           chk("trg_idle", we1, 0);
`else
      tbl[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 12'h005, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 12'h123, 1'b1, 12'h801, 12'h123, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 12'hABC, 1'b1, 12'hC7F, 12'hABC, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 12'h007, 1'b1, 12'h802, 12'h007, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 12'hC80, 12'hFFF, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].fe, tbl[i].v, tbl[i].ch, tbl[i].d);
         chk($sformatf("vec%0d_we", i), we1, tbl[i].we);
         if (tbl[i].we) chk($sformatf("vec%0d_wr", i), {addr1, wdata1}, {tbl[i].addr, 20'b0, tbl[i].data});
         chk($sformatf("vec%0d_busy", i), busy1, tbl[i].busy);
         chk($sformatf("vec%0d_done", i), done1, tbl[i].done);
      end

      // full DECIM=1 record, frame_end on the last sample and on the final write cycle
      do_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      s = done1_cnt;
      for (int k = 0; k < 1280; k++) begin
         cyc(k == 1279, 1, k[0], 12'(k));
         chk($sformatf("t1_wr%0d", k), {we1, addr1, wdata1}, wr(k[0], k / 2, 12'(k)));
      end
      chk("t1_last_addr", addr1, 12'hEFE);
      chk("t1_hold_busy", busy1, 0);
      cyc(1, 0, 0, 0);           chk("t1_done_pulse", {done1, we1}, 2'b10);
      cyc(0, 0, 0, 0);           chk("t1_done_clear", {done1, busy1}, 2'b00);
      nw = 0;
      for (int k = 0; k < 100; k++) begin
         cyc(0, 1, k[0], 12'(k));
         if (we1) nw++;
      end
      chk("hold_no_writes", nw, 0);
      chk("t1_done_count", done1_cnt - s, 1);
      cyc(1, 0, 0, 0);           chk("rearm_busy", busy1, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 12'h055);     chk("rearm_first_wr", {we1, addr1, wdata1}, wr(0, 0, 12'h055));

      // reset in the middle of a record
      for (int k = 1; k < 300; k++) cyc(0, 1, 0, 12'(k));
      cyc(0, 1, 0, 12'h3AB);     chk("mid_wr_idx300", {we1, addr1, wdata1}, {1'b1, 12'h92D, 20'b0, 12'h3AB});
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {we1, busy1, addr1}, 14'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      nw = 0;
      for (int k = 0; k < 10; k++) begin
         cyc(0, 1, k[0], 12'(k));
         if (we1) nw++;
      end
      chk("post_rst_no_writes", nw, 0);
      chk("post_rst_idle", busy1, 0);

      // DECIM=4 on ECG only, then complete EMG
      do_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      s = done4_cnt;
      for (int k = 0; k < 2560; k++) begin
         cyc(0, 1, 0, 12'(k));
         if (k % 4 == 0) chk($sformatf("d4_wr%0d", k), {we4, addr4, wdata4}, wr(0, k / 4, 12'(k)));
         else chk($sformatf("d4_skip%0d", k), we4, 0);
      end
      cyc(0, 1, 0, 12'd2560);
      chk("d4_last_addr", addr4, 12'hA80);
      nw = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(0, 1, 0, 12'(k));
         if (we4) nw++;
      end
      chk("d4_ecg_full_drop", nw, 0);
      chk("d4_still_capture", {busy4, 32'(done4_cnt - s)}, {1'b1, 32'd0});
      nw = 0;
      last_a = '0;
      for (int k = 0; k < 2560; k++) begin
         cyc(0, 1, 1, 12'(k));
         if (we4) begin
            nw++;
            last_a = addr4;
         end
      end
      chk("d4_emg_writes", nw, 640);
      chk("d4_emg_last_addr", last_a, 12'hEFE);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("d4_done_count", done4_cnt - s, 1);
      chk("d4_hold_busy", busy4, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
